// File: rtl/syrk_pkg.sv
// Shared types and constants for the SYRK operand stream transmitter.
package syrk_pkg;

    localparam int unsigned N_DEF  = 100;
    localparam int unsigned DW_DEF = 32;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_C = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        HDR_ALPHA,
        HDR_BETA,
        LOAD_A,
        LOAD_C,
        DRAIN
    } state_t;

endpackage

// File: rtl/syrk_skid_fifo.sv
// Two-entry output buffer; head entry is presented directly on dout.
module syrk_skid_fifo #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [1:0]    count
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    cnt;
    logic          do_push;
    logic          do_pop;

    // A push into a full buffer is only legal when the head leaves in the same cycle
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + 2'(do_push) - 2'(do_pop);
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (cnt == 2'd2);
    assign empty = (cnt == 2'd0);
    assign count = cnt;

endmodule

// File: rtl/syrk_stream_tx.sv
// Emits alpha, beta, A and C (row-major) as one word stream to the SYRK core,
// reading operands from memory under a two-word credit limit.
module syrk_stream_tx
    import syrk_pkg::*;
#(
    parameter  int unsigned N  = N_DEF,
    parameter  int unsigned DW = DW_DEF,
    localparam int unsigned AW = $clog2(N * N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] alpha,
    input  logic [DW-1:0] beta,
    output logic          rd_en,
    output logic          rd_sel,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          busy,
    output logic          done
);

    localparam int unsigned   IW   = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] row;
    logic [IW-1:0] col;
    logic [IW-1:0] row_nxt;
    logic [IW-1:0] col_nxt;
    logic [DW-1:0] alpha_q;
    logic [DW-1:0] beta_q;
    logic          rd_pend;
    logic          accept;
    logic          done_nxt;
    logic          hdr_push;
    logic [DW-1:0] hdr_data;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [1:0]    fifo_cnt;
    logic [DW-1:0] fifo_din;
    logic          space;
    logic [2:0]    occ_eff;

    assign fifo_pop  = !fifo_empty && dout_ready;
    assign space     = !fifo_full || fifo_pop;
    // Occupancy once this cycle's pop has been accounted for
    assign occ_eff   = 3'(fifo_cnt) - 3'(fifo_pop);
    assign fifo_push = hdr_push || rd_pend;
    assign fifo_din  = hdr_push ? hdr_data : rd_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            row     <= '0;
            col     <= '0;
            alpha_q <= '0;
            beta_q  <= '0;
            rd_pend <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            row     <= row_nxt;
            col     <= col_nxt;
            rd_pend <= rd_en;
            busy    <= (state_nxt != IDLE);
            done    <= done_nxt;
            if (accept) begin
                alpha_q <= alpha;
                beta_q  <= beta;
            end
        end
    end

    // First A read is issued alongside beta so A[0] follows beta with no bubble
    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        col_nxt   = col;
        accept    = 1'b0;
        done_nxt  = 1'b0;
        hdr_push  = 1'b0;
        hdr_data  = alpha_q;
        rd_en     = 1'b0;

        case (state)
            IDLE: begin
                if (start && !done) begin
                    accept    = 1'b1;
                    row_nxt   = '0;
                    col_nxt   = '0;
                    state_nxt = HDR_ALPHA;
                end
            end
            HDR_ALPHA: begin
                if (space) begin
                    hdr_push  = 1'b1;
                    state_nxt = HDR_BETA;
                end
            end
            HDR_BETA: begin
                if (space) begin
                    hdr_push  = 1'b1;
                    hdr_data  = beta_q;
                    rd_en     = (occ_eff + 3'd1) < 3'd2;
                    state_nxt = LOAD_A;
                end
            end
            LOAD_A, LOAD_C: begin
                rd_en = (occ_eff + 3'(rd_pend)) < 3'd2;
            end
            DRAIN: begin
                if (!rd_pend && occ_eff == 3'd0) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (rd_en) begin
            if (col == LAST) begin
                col_nxt = '0;
                if (row == LAST) begin
                    row_nxt   = '0;
                    state_nxt = (state == LOAD_A) ? LOAD_C : DRAIN;
                end else begin
                    row_nxt = row + IW'(1);
                end
            end else begin
                col_nxt = col + IW'(1);
            end
        end
    end

    assign rd_sel     = (state == LOAD_C) ? SEL_C : SEL_A;
    assign rd_addr    = AW'(row) * AW'(N) + AW'(col);
    assign dout_valid = !fifo_empty;

    syrk_skid_fifo #(
        .DW(DW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

endmodule
